// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  localparam int DEF_PC_WIDTH    = 8;
  localparam int DEF_RESET_PC    = 0;
  localparam int DEF_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer control strobes plus the fetch address and stack status.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 8
);

  logic                stall;
  logic                branch_en;
  logic [PC_WIDTH-1:0] branch_offset;
  logic                jump_en;
  logic                call_en;
  logic                ret_en;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc;
  logic                stack_empty;
  logic                stack_full;
  logic                overflow_err;
  logic                underflow_err;

  modport master (
    output stall, branch_en, branch_offset, jump_en, call_en, ret_en, jump_target,
    input  pc, stack_empty, stack_full, overflow_err, underflow_err
  );

  modport slave (
    input  stall, branch_en, branch_offset, jump_en, call_en, ret_en, jump_target,
    output pc, stack_empty, stack_full, overflow_err, underflow_err
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO: push writes at count, pop exposes entry count-1 as top.
module ret_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             full;
  logic             empty;

  assign full   = (cnt_p0 == CNT_W'(DEPTH));
  assign empty  = (cnt_p0 == '0);
  assign cnt_m1 = cnt_p0 - CNT_W'(1);
  assign wr_idx = cnt_p0[IDX_W-1:0];
  assign rd_idx = cnt_m1[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (push && !full) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_p0 <= cnt_m1;
    end
  end

  // Entry storage carries no reset; only the count decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push && !full) begin
      entries[wr_idx] <= din;
    end
  end

  assign top   = entries[rd_idx];
  assign count = cnt_p0;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-pc select (ret > call > jump > branch > inc)
// with a return-address stack, stall and registered error pulses.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                  STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC)
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0]        pc_p0;
  logic                       ovf_p0;
  logic                       unf_p0;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic [PC_WIDTH-1:0]        pc_next;
  logic [PC_WIDTH-1:0]        stack_top;
  logic [CNT_W-1:0]           count;
  logic                       empty;
  logic                       full;
  logic                       ovf_next;
  logic                       unf_next;
  logic                       push;
  logic                       pop;
  logic signed [PC_WIDTH-1:0] offset_s;
  pc_sel_e                    sel;

  function automatic logic [PC_WIDTH-1:0] pc_add(
    input logic [PC_WIDTH-1:0]        base,
    input logic signed [PC_WIDTH-1:0] off
  );
    // Same-width add: sign extension and wrap fall out of modulo 2^PC_WIDTH.
    return base + $unsigned(off);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(STACK_DEPTH));
  assign pc_inc   = pc_p0 + PC_WIDTH'(1);
  assign offset_s = $signed(bus.branch_offset);

  // A refused ret/call degrades to a plain increment, never to a lower strobe.
  always_comb begin
    sel      = SEL_INC;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (bus.ret_en) begin
      if (!empty) sel = SEL_RET;
      else        unf_next = 1'b1;
    end else if (bus.call_en) begin
      if (!full) sel = SEL_CALL;
      else       ovf_next = 1'b1;
    end else if (bus.jump_en) begin
      sel = SEL_JUMP;
    end else if (bus.branch_en) begin
      sel = SEL_BRANCH;
    end
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_RET:    pc_next = stack_top;
      SEL_CALL:   pc_next = bus.jump_target;
      SEL_JUMP:   pc_next = bus.jump_target;
      SEL_BRANCH: pc_next = pc_add(pc_inc, offset_s);
      default:    pc_next = pc_inc;
    endcase
  end

  assign push = !bus.stall && (sel == SEL_CALL);
  assign pop  = !bus.stall && (sel == SEL_RET);

  ret_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stack_top),
    .count (count)
  );

  // Stage boundary: pc and error pulses registered; stall holds pc and zeroes errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0  <= RESET_PC;
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
    end else if (bus.stall) begin
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_next;
      ovf_p0 <= ovf_next;
      unf_p0 <= unf_next;
    end
  end

  assign bus.pc            = pc_p0;
  assign bus.stack_empty   = empty;
  assign bus.stack_full    = full;
  assign bus.overflow_err  = ovf_p0;
  assign bus.underflow_err = unf_p0;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer; the next generation of the core's PC block.
- Updates the PC each cycle via increment, signed relative branch, absolute jump, or subroutine call/return through an internal return-address stack.
- Adds stall and reset, neither of which the previous PC had.
- Sits between the decoder (control strobes) and instruction memory (pc drives the fetch address).

Parameters:
PC_WIDTH, 8, width of pc, branch offset and jump target
STACK_DEPTH, 4, return-address stack entries (>=1)
RESET_PC, 0, pc value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold pc and stack this cycle
branch_en  input  1  take relative branch
branch_offset  input  PC_WIDTH  two's-complement offset
jump_en  input  1  absolute jump
call_en  input  1  call: push return address, go to jump_target
ret_en  input  1  return: pop stack into pc
jump_target  input  PC_WIDTH  absolute target for jump/call
pc  output  PC_WIDTH  current fetch address (registered)
stack_empty  output  1  stack holds 0 entries
stack_full  output  1  stack holds STACK_DEPTH entries
overflow_err  output  1  one-cycle pulse: call refused, stack full
underflow_err  output  1  one-cycle pulse: ret refused, stack empty

Behaviour:
Reset:
- Synchronous, active-low; sampled on the rising edge of clk.
- rst_n=0 at an edge sets pc=RESET_PC, stack count=0, and both error outputs to 0. Reset overrides stall and all strobes.
- Stack entry contents are don't-care after reset.

Stall:
- stall=1 holds pc, stack and count, and forces both error pulses to 0. Strobes are ignored in that cycle.

Next-pc selection, one edge of latency, strict priority:
- ret > call > jump > branch > increment.
- ret_en, stack not empty: pc <= top entry; count decrements.
- ret_en, stack empty: pc <= pc+1; underflow_err=1 for the next cycle.
- call_en, not full: entry[count] <= pc+1; count increments; pc <= jump_target.
- call_en, full: nothing is pushed; pc <= pc+1; overflow_err=1 for the next cycle.
- jump_en: pc <= jump_target.
- branch_en: pc <= pc + 1 + sign_extend(branch_offset).
- Otherwise: pc <= pc+1.
- A refused ret/call does not fall through to lower-priority strobes; it is a plain increment.

Arithmetic:
- All pc arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- 8'hFF+1 gives 8'h00.
- Branch offset 8'h80 means -128.

Stack:
- LIFO; count width is clog2(STACK_DEPTH+1).
- Status flags: stack_empty = (count==0); stack_full = (count==STACK_DEPTH). Both are combinational from registered count.
- The pushed return address is pc+1, also wrapped.

Errors:
- overflow_err and underflow_err are registered.
- Each is high exactly one cycle after the offending edge, then clears unless repeated.

Decomposition:
- Shared package pc_pkg holds:
  - next-pc select enum: SEL_INC, SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET;
  - default constants for PC_WIDTH and RESET_PC.
- One sub-module is natural: ret_stack (parametrised LIFO with push, pop, top, count, full, empty).
- pc_sequencer holds the priority select and the pc register.

Test Plan:
1. Reset/increment (PC_WIDTH=8, RESET_PC=8'h10): hold rst_n=0 for 2 edges -> pc=8'h10. Release, 3 idle edges -> pc=8'h13.
2. Branch and wrap: pc=8'h05, branch_en with offset 8'hFD (-3) -> pc=8'h03. Then pc=8'hFF with no strobes -> pc=8'h00.
3. Call/return nesting (STACK_DEPTH=2):
   - pc=8'h20, call to 8'h40 -> pc=8'h40, stack_empty=0.
   - call to 8'h60 -> pc=8'h60, stack_full=1.
   - ret -> pc=8'h41; ret -> pc=8'h21, stack_empty=1.
4. Overflow/underflow:
   - Stack full at pc=8'h60, call to 8'h80 -> pc=8'h61, overflow_err high for one cycle, stack unchanged.
   - Stack empty, ret -> pc+1, underflow_err pulses once.
5. Priority and stall:
   - ret_en, call_en, jump_en and branch_en all 1 with stack non-empty -> only the pop happens.
   - stall=1 with call_en=1 for 3 edges -> pc and count unchanged, no error pulse.
6. Reset mid-operation: stack at count 2 and pc=8'h60, assert rst_n=0 together with call_en -> pc=RESET_PC, stack_empty=1, errors 0.
